// File: rtl/uart_wb_slave32_if.sv
// uart_wb_slave32_if: WISHBONE classic bus signals between a bus master and the UART slave front end
interface uart_wb_slave32_if #(parameter int ADDR_WIDTH = 5);
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [31:0]           wb_dat_i;
  logic [3:0]            wb_sel_i;
  logic                  wb_we_i;
  logic                  wb_stb_i;
  logic                  wb_cyc_i;
  logic [31:0]           wb_dat_o;
  logic                  wb_ack_o;
  logic                  wb_err_o;
  modport master (output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i, input wb_dat_o, wb_ack_o, wb_err_o);
  modport slave (input wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i, output wb_dat_o, wb_ack_o, wb_err_o);
endinterface

// File: rtl/uart_wb_slave32.sv
// uart_wb_slave32: 32-bit WISHBONE slave turning bus cycles into byte register strobes and word debug reads
module uart_wb_slave32 #(
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] DBG_ADR0   = 5'h08,
  parameter logic [ADDR_WIDTH-1:0] DBG_ADR1   = 5'h0C
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  uart_wb_slave32_if.slave      wb,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [7:0]            reg_dat_o,
  output logic                  re_o,
  output logic                  we_o,
  input  logic [7:0]            reg_dat_i,
  input  logic [31:0]           dbg_dat32_i
);
  typedef enum logic [1:0] {IDLE, STROBE, ACK} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-3:0] w_word;
  logic [1:0]            w_lane, r_lane;
  logic                  w_req, w_is_dbg, w_onehot, w_byte, w_dbg, w_unused_adr;
  logic                  r_we, r_byte, r_dbg, r_re, r_we_o, r_ack, r_err;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [7:0]            r_reg_dat;
  logic [31:0]           r_dat_o, w_rd;
  assign w_req        = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_word       = wb.wb_adr_i[ADDR_WIDTH-1:2];
  assign w_unused_adr = ^wb.wb_adr_i[1:0];
  assign w_is_dbg     = (w_word == DBG_ADR0[ADDR_WIDTH-1:2]) | (w_word == DBG_ADR1[ADDR_WIDTH-1:2]);
  assign w_onehot     = $onehot(wb.wb_sel_i);
  assign w_lane       = wb.wb_sel_i[3] ? 2'd3 : wb.wb_sel_i[2] ? 2'd2 : wb.wb_sel_i[1] ? 2'd1 : 2'd0;
  assign w_byte       = ~w_is_dbg & w_onehot;
  assign w_dbg        = w_is_dbg & (wb.wb_sel_i == 4'hF) & ~wb.wb_we_i;
  assign w_rd         = {24'h0, reg_dat_i} << {r_lane, 3'b000};
  assign adr_o        = r_adr;
  assign reg_dat_o    = r_reg_dat;
  assign re_o         = r_re;
  assign we_o         = r_we_o;
  assign wb.wb_dat_o  = r_dat_o;
  assign wb.wb_ack_o  = r_ack;
  assign wb.wb_err_o  = r_err;
  // Next state: accept in IDLE, abort from STROBE when the master drops cyc, ACK always returns to IDLE
  always_comb begin
    w_next = (r_state == IDLE) ? (w_req ? STROBE : IDLE) : (r_state == STROBE) ? (wb.wb_cyc_i ? ACK : IDLE) : IDLE;
  end
  // State register plus request capture, strobe pulses, read data return and termination pulses
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_byte    <= 1'b0;
      r_dbg     <= 1'b0;
      r_lane    <= 2'd0;
      r_adr     <= '0;
      r_reg_dat <= 8'h0;
      r_re      <= 1'b0;
      r_we_o    <= 1'b0;
      r_dat_o   <= 32'h0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_re    <= 1'b0;
      r_we_o  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == IDLE && w_req) begin
        r_we   <= wb.wb_we_i;
        r_byte <= w_byte;
        r_dbg  <= w_dbg;
        r_lane <= w_lane;
        r_adr  <= w_byte ? {w_word, w_lane} : {w_word, 2'b00};
        r_re   <= w_byte & ~wb.wb_we_i;
        r_we_o <= w_byte & wb.wb_we_i;
        if (w_byte) r_reg_dat <= wb.wb_dat_i[{w_lane, 3'b000} +: 8];
      end
      if (r_state == STROBE) begin
        if (r_byte & ~r_we) r_dat_o <= w_rd;
        else if (r_dbg) r_dat_o <= dbg_dat32_i;
        r_ack <= wb.wb_cyc_i & (r_byte | r_dbg);
        r_err <= wb.wb_cyc_i & ~(r_byte | r_dbg);
      end
    end
  end
endmodule

// File: tb/tb_uart_wb_slave32.sv
// tb_uart_wb_slave32: directed and randomized bus accesses checked against a rule-level reference model
module tb_uart_wb_slave32;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [4:0]  adr_o;
  logic [7:0]  reg_dat_o;
  logic        re_o, we_o;
  logic [7:0]  reg_dat_i;
  logic [31:0] dbg_dat32_i;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_dat;
  bit          m_known;

  uart_wb_slave32_if #(.ADDR_WIDTH(5)) bus();

  uart_wb_slave32 dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wb          (bus),
    .adr_o       (adr_o),
    .reg_dat_o   (reg_dat_o),
    .re_o        (re_o),
    .we_o        (we_o),
    .reg_dat_i   (reg_dat_i),
    .dbg_dat32_i (dbg_dat32_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dat"}, bus.wb_dat_o, 32'h0);
    chk({tag, "_ack"}, 32'(bus.wb_ack_o), 32'h0);
    chk({tag, "_err"}, 32'(bus.wb_err_o), 32'h0);
    chk({tag, "_adr"}, 32'(adr_o), 32'h0);
    chk({tag, "_regdat"}, 32'(reg_dat_o), 32'h0);
    chk({tag, "_re"}, 32'(re_o), 32'h0);
    chk({tag, "_we"}, 32'(we_o), 32'h0);
  endtask

  task automatic drive(input logic [4:0] a, input logic [3:0] s, input bit w, input logic [31:0] d,
                       input logic [7:0] rd, input logic [31:0] dd);
    bus.wb_adr_i = a;
    bus.wb_sel_i = s;
    bus.wb_we_i  = w;
    bus.wb_dat_i = d;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    reg_dat_i    = rd;
    dbg_dat32_i  = dd;
  endtask

  task automatic idle_bus();
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
  endtask

  // One bus access; expectations come from the address map and lane rules, not from the DUT
  task automatic access(input logic [4:0] a, input logic [3:0] s, input bit w, input logic [31:0] d,
                        input logic [7:0] rd, input logic [31:0] dd, input bit drop);
    int word, lane;
    bit is_dbg, onehot, byte_ok, dbg_ok, legal, rdacc;
    logic [4:0] eadr;
    word    = int'(a) / 4;
    is_dbg  = (word == 2) || (word == 3);
    onehot  = (s != 4'h0) && ((s & (s - 4'h1)) == 4'h0);
    lane    = 0;
    for (int i = 0; i < 4; i++) if (s[i]) lane = i;
    byte_ok = !is_dbg && onehot;
    dbg_ok  = is_dbg && (s == 4'hF) && !w;
    legal   = byte_ok || dbg_ok;
    rdacc   = legal && !w;
    eadr    = byte_ok ? 5'(word * 4 + lane) : 5'(word * 4);
    @(negedge wb_clk_i);
    drive(a, s, w, d, rd, dd);
    @(negedge wb_clk_i);
    chk("strobe_re", 32'(re_o), 32'(byte_ok && !w));
    chk("strobe_we", 32'(we_o), 32'(byte_ok && w));
    chk("strobe_ack", 32'(bus.wb_ack_o), 32'h0);
    chk("strobe_err", 32'(bus.wb_err_o), 32'h0);
    if (legal) chk("strobe_adr", 32'(adr_o), 32'(eadr));
    if (byte_ok && w) chk("strobe_regdat", 32'(reg_dat_o), (d >> (8 * lane)) & 32'hFF);
    if (byte_ok && !w) m_dat = 32'(rd) << (8 * lane);
    else if (dbg_ok) m_dat = dd;
    if (drop) begin
      idle_bus();
      if (rdacc) m_known = 1'b0;
    end else if (rdacc) m_known = 1'b1;
    @(negedge wb_clk_i);
    chk("term_ack", 32'(bus.wb_ack_o), 32'(legal && !drop));
    chk("term_err", 32'(bus.wb_err_o), 32'(!legal && !drop));
    chk("term_re", 32'(re_o), 32'h0);
    chk("term_we", 32'(we_o), 32'h0);
    if (legal && !drop && m_known) chk("term_dat", bus.wb_dat_o, m_dat);
    idle_bus();
    @(negedge wb_clk_i);
    chk("after_ack", 32'(bus.wb_ack_o), 32'h0);
    chk("after_err", 32'(bus.wb_err_o), 32'h0);
    if (legal) chk("after_adr", 32'(adr_o), 32'(eadr));
  endtask

  initial begin
    logic [3:0] s;
    int pick;
    bus.wb_adr_i = 5'h0;
    bus.wb_dat_i = 32'h0;
    bus.wb_sel_i = 4'h0;
    bus.wb_we_i  = 1'b0;
    idle_bus();
    reg_dat_i    = 8'h0;
    dbg_dat32_i  = 32'h0;
    m_dat        = 32'h0;
    m_known      = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      chk_zero("idle");
    end
    access(5'h04, 4'b0100, 1'b1, 32'h00A50000, 8'h00, 32'h0, 1'b0);
    access(5'h00, 4'b0010, 1'b0, 32'h0, 8'h3C, 32'h0, 1'b0);
    chk("read_lane1", bus.wb_dat_o, 32'h00003C00);
    access(5'h08, 4'hF, 1'b0, 32'h0, 8'h00, 32'hDEADBEEF, 1'b0);
    chk("dbg_read", bus.wb_dat_o, 32'hDEADBEEF);
    access(5'h0C, 4'hF, 1'b1, 32'h12345678, 8'h00, 32'h0, 1'b0);
    access(5'h00, 4'b0011, 1'b0, 32'h0, 8'h55, 32'h0, 1'b0);
    access(5'h10, 4'b1000, 1'b0, 32'h0, 8'h77, 32'h0, 1'b1);
    access(5'h14, 4'b0001, 1'b0, 32'h0, 8'h81, 32'h0, 1'b0);
    @(negedge wb_clk_i);
    drive(5'h18, 4'b0001, 1'b1, 32'h000000EE, 8'h00, 32'h0);
    @(negedge wb_clk_i);
    chk("rst_mid_we", 32'(we_o), 32'h1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk_zero("rst_mid");
    wb_rst_i = 1'b0;
    idle_bus();
    m_dat   = 32'h0;
    m_known = 1'b1;
    @(negedge wb_clk_i);
    chk_zero("post_rst");
    access(5'h1C, 4'b0100, 1'b0, 32'h0, 8'h9A, 32'h0, 1'b0);
    for (int n = 0; n < 80; n++) begin
      pick = int'($urandom_range(0, 3));
      s = (pick == 0) ? 4'($urandom_range(0, 15)) : (pick == 1) ? 4'hF : 4'(1 << $urandom_range(0, 3));
      access(5'($urandom_range(0, 31)), s, 1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)),
             $urandom, $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge wb_clk_i);
        chk("gap_re", 32'(re_o), 32'h0);
        chk("gap_we", 32'(we_o), 32'h0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
